ethernet_sys_descriptor_walker: RTL and testbench

- Avalon-MM master that walks a linked chain of 4-word DMA descriptors held in the on-chip descriptor memory. The memory is 1024 x 32, with a 1-cycle read latency and byte enables.
- For each descriptor owned by hardware, it:
  - fetches the descriptor,
  - hands the buffer command to the downstream Ethernet DMA over a valid/ready interface,
  - waits for completion,
  - writes status back into the descriptor memory,
  - follows the next pointer.
- Sits between the CPU-built descriptor ring (memory port s2) and the TSE frame DMA.

---
 rtl/ethernet_sys_descriptor_walker_if.sv | 40 ++++
 rtl/ethernet_sys_descriptor_walker.sv | 195 +++++++++++++++++++
 tb/tb_ethernet_sys_descriptor_walker.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ethernet_sys_descriptor_walker_if.sv
// Bus bundle between the descriptor walker, the descriptor memory (Avalon-MM)
// and the downstream Ethernet frame DMA (command valid/ready + completion pulse).
interface ethernet_sys_descriptor_walker_if #(
  parameter int unsigned ADDR_W = 10
);
  // Avalon-MM descriptor memory port
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic              avm_clken;
  logic [31:0]       avm_readdata;

  // Buffer command to the DMA and its completion report
  logic              desc_valid;
  logic              desc_ready;
  logic [31:0]       desc_buf_addr;
  logic [15:0]       desc_len;
  logic [7:0]        desc_ctrl;
  logic              cmpl_valid;
  logic [15:0]       cmpl_len;
  logic [7:0]        cmpl_status;

  modport master (
    output avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata, avm_clken,
    input  avm_readdata,
    output desc_valid, desc_buf_addr, desc_len, desc_ctrl,
    input  desc_ready,
    input  cmpl_valid, cmpl_len, cmpl_status
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata, avm_clken,
    output avm_readdata,
    input  desc_valid, desc_buf_addr, desc_len, desc_ctrl,
    output desc_ready,
    output cmpl_valid, cmpl_len, cmpl_status
  );
endinterface

// File: rtl/ethernet_sys_descriptor_walker.sv
// Walks a linked chain of 4-word DMA descriptors in on-chip memory, hands each
// hardware-owned buffer to the frame DMA and writes completion status back.
module ethernet_sys_descriptor_walker #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W+1:0] head_ptr,
  input  logic              abort,
  output logic              busy,
  output logic              chain_done,
  output logic              error,
  output logic [15:0]       desc_count,
  ethernet_sys_descriptor_walker_if.master bus
);

  localparam int unsigned DI_W = ADDR_W - 2;
  localparam int unsigned FC_W = 3;
  localparam logic [FC_W-1:0] CAP_W0 = FC_W'(READ_LATENCY);
  localparam logic [FC_W-1:0] CAP_W1 = FC_W'(READ_LATENCY + 1);
  localparam logic [FC_W-1:0] CAP_W2 = FC_W'(READ_LATENCY + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_PRESENT,
    S_WAIT_CMPL,
    S_WB_STATUS,
    S_WB_OWN,
    S_NEXT
  } state_e;

  state_e            state_q;
  logic [DI_W-1:0]   base_q;
  logic [FC_W-1:0]   fcnt_q;
  logic [31:0]       w0_q;
  logic [31:0]       w1_q;
  logic [31:0]       w2_q;
  logic              busy_q;
  logic              chain_done_q;
  logic              error_q;
  logic [15:0]       desc_count_q;
  logic [ADDR_W-1:0] avm_address_q;
  logic              avm_chipselect_q;
  logic              avm_write_q;
  logic [3:0]        avm_byteenable_q;
  logic [31:0]       avm_writedata_q;
  logic              desc_valid_q;
  logic              next_bad_c;

  // Next pointer must be 16-byte aligned and inside the descriptor memory
  assign next_bad_c = (w1_q[3:0] != 4'h0) || (w1_q[31:ADDR_W+2] != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      base_q           <= '0;
      fcnt_q           <= '0;
      w0_q             <= '0;
      w1_q             <= '0;
      w2_q             <= '0;
      busy_q           <= 1'b0;
      chain_done_q     <= 1'b0;
      error_q          <= 1'b0;
      desc_count_q     <= '0;
      avm_address_q    <= '0;
      avm_chipselect_q <= 1'b0;
      avm_write_q      <= 1'b0;
      avm_byteenable_q <= '0;
      avm_writedata_q  <= '0;
      desc_valid_q     <= 1'b0;
    end else begin
      chain_done_q <= 1'b0;
      error_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (head_ptr[3:0] == 4'h0) begin
              base_q           <= head_ptr[ADDR_W+1:4];
              desc_count_q     <= '0;
              busy_q           <= 1'b1;
              fcnt_q           <= '0;
              avm_chipselect_q <= 1'b1;
              avm_write_q      <= 1'b0;
              avm_byteenable_q <= 4'hF;
              avm_address_q    <= {head_ptr[ADDR_W+1:4], 2'd0};
              state_q          <= S_FETCH;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        // Reads on fcnt 0..2; word k lands READ_LATENCY cycles after its read
        S_FETCH: begin
          fcnt_q <= fcnt_q + FC_W'(1);
          if (fcnt_q < FC_W'(2)) begin
            avm_address_q <= {base_q, 2'(fcnt_q + FC_W'(1))};
          end else begin
            avm_chipselect_q <= 1'b0;
            avm_byteenable_q <= '0;
            avm_address_q    <= '0;
          end
          if (fcnt_q == CAP_W0) w0_q <= bus.avm_readdata;
          if (fcnt_q == CAP_W1) w1_q <= bus.avm_readdata;
          if (fcnt_q == CAP_W2) begin
            w2_q    <= bus.avm_readdata;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w2_q[31]) begin
            desc_valid_q <= 1'b1;
            state_q      <= S_PRESENT;
          end else begin
            chain_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        S_PRESENT: begin
          if (bus.desc_ready) begin
            desc_valid_q <= 1'b0;
            state_q      <= S_WAIT_CMPL;
          end
        end
        S_WAIT_CMPL: begin
          if (bus.cmpl_valid) begin
            avm_chipselect_q <= 1'b1;
            avm_write_q      <= 1'b1;
            avm_byteenable_q <= 4'hF;
            avm_address_q    <= {base_q, 2'd3};
            avm_writedata_q  <= {1'b1, 7'b0, bus.cmpl_status, bus.cmpl_len};
            state_q          <= S_WB_STATUS;
          end
        end
        // Hand ownership back: only the top byte lane is written
        S_WB_STATUS: begin
          avm_address_q    <= {base_q, 2'd2};
          avm_byteenable_q <= 4'b1000;
          avm_writedata_q  <= {1'b0, w2_q[30:0]};
          state_q          <= S_WB_OWN;
        end
        S_WB_OWN: begin
          avm_chipselect_q <= 1'b0;
          avm_write_q      <= 1'b0;
          avm_byteenable_q <= '0;
          avm_address_q    <= '0;
          avm_writedata_q  <= '0;
          if (desc_count_q != 16'hFFFF) desc_count_q <= desc_count_q + 16'd1;
          state_q <= S_NEXT;
        end
        S_NEXT: begin
          if (abort || (w1_q == 32'd0)) begin
            chain_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else if (next_bad_c) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            base_q           <= w1_q[ADDR_W+1:4];
            fcnt_q           <= '0;
            avm_chipselect_q <= 1'b1;
            avm_write_q      <= 1'b0;
            avm_byteenable_q <= 4'hF;
            avm_address_q    <= {w1_q[ADDR_W+1:4], 2'd0};
            state_q          <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign chain_done = chain_done_q;
  assign error      = error_q;
  assign desc_count = desc_count_q;

  assign bus.avm_address    = avm_address_q;
  assign bus.avm_chipselect = avm_chipselect_q;
  assign bus.avm_write      = avm_write_q;
  assign bus.avm_byteenable = avm_byteenable_q;
  assign bus.avm_writedata  = avm_writedata_q;
  assign bus.avm_clken      = 1'b1;
  assign bus.desc_valid     = desc_valid_q;
  assign bus.desc_buf_addr  = w0_q;
  assign bus.desc_len       = w2_q[15:0];
  assign bus.desc_ctrl      = w2_q[23:16];

endmodule

// File: tb/tb_ethernet_sys_descriptor_walker.sv
// Bench for the descriptor walker: memory model, DMA model with a command
// scoreboard, table of single-descriptor vectors and chain/abort/reset sequences.
module tb_ethernet_sys_descriptor_walker;
  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W+1:0] head_ptr;
  logic              abort;
  logic              busy;
  logic              chain_done;
  logic              error;
  logic [15:0]       desc_count;

  ethernet_sys_descriptor_walker_if #(.ADDR_W(ADDR_W)) bus ();

  ethernet_sys_descriptor_walker #(.ADDR_W(ADDR_W), .READ_LATENCY(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .head_ptr   (head_ptr),
    .abort      (abort),
    .busy       (busy),
    .chain_done (chain_done),
    .error      (error),
    .desc_count (desc_count),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] buf_addr;
    logic [15:0] len;
    logic [7:0]  ctrl;
    logic [15:0] cl;
    logic [7:0]  cst;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] mem [0:1023];
  int          rd_hit [1024];
  int          wr_hit [1024];
  int          rd_tot = 0, wr_tot = 0;
  int          n_chk = 0, n_err = 0;
  int          cd_cnt = 0, er_cnt = 0, busy_cyc = 0, hs_cnt = 0;
  int          ready_dly = 0, cmpl_dly = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Descriptor memory: 1-cycle read latency, byte-lane writes
  always @(posedge clk) begin
    if (bus.avm_chipselect) begin
      if (bus.avm_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.avm_byteenable[b]) mem[bus.avm_address][8*b +: 8] = bus.avm_writedata[8*b +: 8];
        wr_hit[bus.avm_address] = wr_hit[bus.avm_address] + 1;
        wr_tot = wr_tot + 1;
      end else begin
        bus.avm_readdata <= mem[bus.avm_address];
        rd_hit[bus.avm_address] = rd_hit[bus.avm_address] + 1;
        rd_tot = rd_tot + 1;
      end
    end
  end

  // Pulse/busy monitor
  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (chain_done) cd_cnt++;
    if (error) er_cnt++;
    if (chain_done || error) begin
      chk("pulse_busy_low", 32'(busy), 32'd0);
      chk("pulse_exclusive", 32'(chain_done & error), 32'd0);
    end
  end

  // DMA model: delayed ready, field stability, scoreboard pop, completion pulse
  initial begin
    sb_t f, e;
    bus.desc_ready  = 1'b0;
    bus.cmpl_valid  = 1'b0;
    bus.cmpl_len    = '0;
    bus.cmpl_status = '0;
    forever begin
      @(negedge clk);
      if (bus.desc_valid) begin
        f.buf_addr = bus.desc_buf_addr;
        f.len      = bus.desc_len;
        f.ctrl     = bus.desc_ctrl;
        for (int i = 0; i < ready_dly; i++) begin
          @(negedge clk);
          chk("stable_valid", 32'(bus.desc_valid), 32'd1);
          chk("stable_buf", bus.desc_buf_addr, f.buf_addr);
          chk("stable_lenctrl", {8'd0, bus.desc_ctrl, bus.desc_len}, {8'd0, f.ctrl, f.len});
        end
        bus.desc_ready = 1'b1;
        @(negedge clk);
        bus.desc_ready = 1'b0;
        hs_cnt++;
        chk("valid_dropped", 32'(bus.desc_valid), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_cmd", 32'(sb.size()), 32'd1);
          e = '{32'd0, 16'd0, 8'd0, 16'd0, 8'd0};
        end else begin
          e = sb.pop_front();
          chk("cmd_buf_addr", f.buf_addr, e.buf_addr);
          chk("cmd_len", 32'(f.len), 32'(e.len));
          chk("cmd_ctrl", 32'(f.ctrl), 32'(e.ctrl));
        end
        for (int i = 0; i < cmpl_dly; i++) @(negedge clk);
        bus.cmpl_valid  = 1'b1;
        bus.cmpl_len    = e.cl;
        bus.cmpl_status = e.cst;
        @(negedge clk);
        bus.cmpl_valid  = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = 32'd0;
      rd_hit[i] = 0;
      wr_hit[i] = 0;
    end
  endtask

  task automatic put_desc(input logic [11:0] ba, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2);
    mem[ba[11:2]]         = w0;
    mem[ba[11:2] + 10'd1] = w1;
    mem[ba[11:2] + 10'd2] = w2;
    mem[ba[11:2] + 10'd3] = 32'd0;
  endtask

  task automatic push_exp(input logic [31:0] b, input logic [31:0] w2, input logic [15:0] cl,
                          input logic [7:0] cst);
    sb.push_back('{b, w2[15:0], w2[23:16], cl, cst});
  endtask

  // Pulse start at h and wait (bounded) for chain_done or error
  task automatic run(input logic [11:0] h, input bit poke, output int bcyc);
    int cd0 = cd_cnt, e0 = er_cnt, hs0 = hs_cnt, bc0 = busy_cyc;
    bit ended = 0, poked = 0;
    @(negedge clk);
    head_ptr = h;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && !ended; i++) begin
      @(negedge clk); #1;
      start = 1'b0;
      if (cd_cnt != cd0 || er_cnt != e0) ended = 1;
      else if (poke && !poked && hs_cnt != hs0) begin
        abort    = 1'b1;
        head_ptr = 12'h300;
        start    = 1'b1;
        poked    = 1;
      end
    end
    start = 1'b0;
    if (!ended) chk("timeout_end", 32'(cd_cnt - cd0 + er_cnt - e0), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    abort = 1'b0;
    bcyc  = busy_cyc - bc0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_err"}, 32'({chain_done, error}), 32'd0);
    chk({tag, "_count"}, 32'(desc_count), 32'd0);
    chk({tag, "_cs_wr"}, 32'({bus.avm_chipselect, bus.avm_write}), 32'd0);
    chk({tag, "_addr_be"}, 32'({bus.avm_address, bus.avm_byteenable}), 32'd0);
    chk({tag, "_wdata"}, bus.avm_writedata, 32'd0);
    chk({tag, "_clken"}, 32'(bus.avm_clken), 32'd1);
    chk({tag, "_dvalid"}, 32'(bus.desc_valid), 32'd0);
  endtask

  typedef struct {
    logic [11:0] base;
    logic [31:0] w0;
    logic [31:0] w2;
    logic [15:0] cl;
    logic [7:0]  cst;
    logic [31:0] exp_w3;
    logic [31:0] exp_w2;
    int          rdly;
    int          cdly;
    int          exp_busy;
  } vec_t;

  initial begin
    vec_t tv[3];
    int bc, cd0, e0, r0, w0, hs0;
    logic [9:0] wi;

    tv[0] = '{12'h040, 32'h1000_0000, 32'h8003_0040, 16'd64,    8'h01, 32'h8001_0040, 32'h0003_0040, 0, 0, 10};
    tv[1] = '{12'h3F0, 32'hDEAD_BEEC, 32'h80FF_0000, 16'd0,     8'hAA, 32'h80AA_0000, 32'h00FF_0000, 2, 3, 15};
    tv[2] = '{12'h080, 32'h0000_0004, 32'hFE12_3456, 16'hFFFF, 8'h7F, 32'h807F_FFFF, 32'h7E12_3456, 1, 0, 11};

    reset = 1'b1; start = 1'b0; abort = 1'b0; head_ptr = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    #1;
    chk_idle("reset");
    reset = 1'b0;
    @(negedge clk); #1;
    chk_idle("post_reset");

    // Table of single-descriptor chains
    for (int k = 0; k < 3; k++) begin
      clear_mem();
      put_desc(tv[k].base, tv[k].w0, 32'd0, tv[k].w2);
      push_exp(tv[k].w0, tv[k].w2, tv[k].cl, tv[k].cst);
      ready_dly = tv[k].rdly;
      cmpl_dly  = tv[k].cdly;
      cd0 = cd_cnt; r0 = rd_tot; w0 = wr_tot;
      run(tv[k].base, 0, bc);
      wi = tv[k].base[11:2];
      chk($sformatf("v%0d_w3", k), mem[wi + 10'd3], tv[k].exp_w3);
      chk($sformatf("v%0d_w2", k), mem[wi + 10'd2], tv[k].exp_w2);
      chk($sformatf("v%0d_w0", k), mem[wi], tv[k].w0);
      chk($sformatf("v%0d_count", k), 32'(desc_count), 32'd1);
      chk($sformatf("v%0d_done", k), 32'(cd_cnt - cd0), 32'd1);
      chk($sformatf("v%0d_cycles", k), 32'(bc), 32'(tv[k].exp_busy));
      chk($sformatf("v%0d_rw", k), 32'((rd_tot - r0) * 16 + (wr_tot - w0)), 32'h32);
    end

    // Chain of three with slow ready
    clear_mem();
    put_desc(12'h000, 32'hA000_0000, 32'h100, 32'h8001_0010);
    put_desc(12'h100, 32'hA000_1000, 32'h200, 32'h8002_0020);
    put_desc(12'h200, 32'hA000_2000, 32'h000, 32'h8003_0030);
    push_exp(32'hA000_0000, 32'h8001_0010, 16'h10, 8'h00);
    push_exp(32'hA000_1000, 32'h8002_0020, 16'h20, 8'h01);
    push_exp(32'hA000_2000, 32'h8003_0030, 16'h30, 8'h02);
    ready_dly = 5; cmpl_dly = 1;
    cd0 = cd_cnt; hs0 = hs_cnt;
    run(12'h000, 0, bc);
    chk("chain_hs", 32'(hs_cnt - hs0), 32'd3);
    chk("chain_count", 32'(desc_count), 32'd3);
    chk("chain_done", 32'(cd_cnt - cd0), 32'd1);
    chk("chain_w3_0", mem[10'h003], 32'h8000_0010);
    chk("chain_w3_1", mem[10'h043], 32'h8001_0020);
    chk("chain_w3_2", mem[10'h083], 32'h8002_0030);
    chk("chain_w2_2", mem[10'h082], 32'h0003_0030);

    // Third descriptor not owned by hardware
    clear_mem();
    put_desc(12'h000, 32'hB000_0000, 32'h100, 32'h8001_0010);
    put_desc(12'h100, 32'hB000_1000, 32'h200, 32'h8002_0020);
    put_desc(12'h200, 32'hB000_2000, 32'h000, 32'h0003_0030);
    push_exp(32'hB000_0000, 32'h8001_0010, 16'h11, 8'h04);
    push_exp(32'hB000_1000, 32'h8002_0020, 16'h22, 8'h05);
    ready_dly = 0; cmpl_dly = 0;
    cd0 = cd_cnt; hs0 = hs_cnt; w0 = wr_tot;
    run(12'h000, 0, bc);
    chk("own0_hs", 32'(hs_cnt - hs0), 32'd2);
    chk("own0_count", 32'(desc_count), 32'd2);
    chk("own0_done", 32'(cd_cnt - cd0), 32'd1);
    chk("own0_writes", 32'(wr_tot - w0), 32'd4);
    chk("own0_no_wr3", 32'(wr_hit[10'h080] + wr_hit[10'h081] + wr_hit[10'h082] + wr_hit[10'h083]), 32'd0);
    chk("own0_rd_w2", 32'(rd_hit[10'h082]), 32'd1);

    // Misaligned head pointer
    clear_mem();
    cd0 = cd_cnt; e0 = er_cnt; r0 = rd_tot; w0 = wr_tot;
    run(12'h044, 0, bc);
    chk("mis_head_err", 32'(er_cnt - e0), 32'd1);
    chk("mis_head_done", 32'(cd_cnt - cd0), 32'd0);
    chk("mis_head_acc", 32'((rd_tot - r0) + (wr_tot - w0)), 32'd0);
    chk("mis_head_busy", 32'(bc), 32'd0);

    // Misaligned next pointer: descriptor finishes, then error
    clear_mem();
    put_desc(12'h100, 32'hC000_0000, 32'h208, 32'h8000_0100);
    push_exp(32'hC000_0000, 32'h8000_0100, 16'h100, 8'h09);
    e0 = er_cnt; cd0 = cd_cnt;
    run(12'h100, 0, bc);
    chk("mis_next_err", 32'(er_cnt - e0), 32'd1);
    chk("mis_next_done", 32'(cd_cnt - cd0), 32'd0);
    chk("mis_next_w3", mem[10'h043], 32'h8009_0100);
    chk("mis_next_wr_own", 32'(wr_hit[10'h042]), 32'd1);
    chk("mis_next_no_rd", 32'(rd_hit[10'h082]), 32'd0);
    chk("mis_next_count", 32'(desc_count), 32'd1);

    // Out-of-range next pointer
    clear_mem();
    put_desc(12'h000, 32'hC100_0000, 32'h0000_1000, 32'h8000_0008);
    push_exp(32'hC100_0000, 32'h8000_0008, 16'h8, 8'h00);
    e0 = er_cnt; r0 = rd_tot;
    run(12'h000, 0, bc);
    chk("range_err", 32'(er_cnt - e0), 32'd1);
    chk("range_reads", 32'(rd_tot - r0), 32'd3);

    // Abort during completion wait, plus a start while busy
    clear_mem();
    put_desc(12'h000, 32'hD000_0000, 32'h100, 32'h8001_0010);
    put_desc(12'h100, 32'hD000_1000, 32'h200, 32'h8002_0020);
    put_desc(12'h200, 32'hD000_2000, 32'h000, 32'h8003_0030);
    put_desc(12'h300, 32'hD000_3000, 32'h000, 32'h8004_0040);
    push_exp(32'hD000_0000, 32'h8001_0010, 16'h40, 8'h03);
    cmpl_dly = 4;
    cd0 = cd_cnt; e0 = er_cnt;
    run(12'h000, 1, bc);
    cmpl_dly = 0;
    chk("abort_done", 32'(cd_cnt - cd0), 32'd1);
    chk("abort_err", 32'(er_cnt - e0), 32'd0);
    chk("abort_count", 32'(desc_count), 32'd1);
    chk("abort_w3", mem[10'h003], 32'h8003_0040);
    chk("abort_w2", mem[10'h002], 32'h0001_0010);
    chk("abort_no_rd2", 32'(rd_hit[10'h040] + rd_hit[10'h041] + rd_hit[10'h042]), 32'd0);
    chk("busy_start_ign", 32'(rd_hit[10'h0C0]), 32'd0);

    // Reset during FETCH
    clear_mem();
    put_desc(12'h040, 32'hE000_0000, 32'h0, 32'h8000_0001);
    w0 = wr_tot;
    @(negedge clk); head_ptr = 12'h040; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    chk_idle("rst_fetch");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk); #1;
    chk("rst_fetch_nowr", 32'(wr_tot - w0), 32'd0);
    chk("rst_fetch_idle", 32'(busy), 32'd0);

    // Reset during WB_STATUS
    clear_mem();
    put_desc(12'h080, 32'hE100_0000, 32'h0, 32'h8000_0002);
    push_exp(32'hE100_0000, 32'h8000_0002, 16'h2, 8'h00);
    begin
      bit seen = 0;
      @(negedge clk); head_ptr = 12'h080; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk); #1;
        if (bus.avm_write && bus.avm_byteenable == 4'hF) seen = 1;
      end
      chk("rst_wb_seen", 32'(seen), 32'd1);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    chk_idle("rst_wb");
    reset = 1'b0;
    repeat (3) @(negedge clk); #1;
    chk("rst_wb_no_own_wr", 32'(wr_hit[10'h022]), 32'd0);
    chk("rst_wb_own_kept", mem[10'h022], 32'h8000_0002);

    // Fresh start after reset
    clear_mem();
    put_desc(12'h080, 32'hE200_0000, 32'h0, 32'h8005_0050);
    push_exp(32'hE200_0000, 32'h8005_0050, 16'h50, 8'h06);
    cd0 = cd_cnt;
    run(12'h080, 0, bc);
    chk("fresh_done", 32'(cd_cnt - cd0), 32'd1);
    chk("fresh_count", 32'(desc_count), 32'd1);
    chk("fresh_w3", mem[10'h023], 32'h8006_0050);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
